// File: rtl/fix_pkg.sv
// Shared constants and state type for the FIX checksum trailer path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fix_pkg;

  localparam logic [7:0] SOH      = 8'h01;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_EQ = 8'h3D;

  // Trailer "10=NNN<SOH>" is seven bytes; index runs 0..6.
  localparam int         CHK_TAG_LEN = 7;
  localparam logic [2:0] LAST_IDX    = 3'(CHK_TAG_LEN - 1);

  typedef enum logic {
    PASS  = 1'b0,
    TRAIL = 1'b1
  } state_t;

endpackage

// File: rtl/chk_to_ascii3.sv
// Converts an 8-bit value to three zero-padded ASCII decimal digits.
// Latency: combinational.
// Backpressure: none, pure function of the input.
module chk_to_ascii3
  import fix_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] hund,
  output logic [7:0] tens,
  output logic [7:0] ones
);

  logic [7:0] h_val;
  logic [7:0] t_val;
  logic [7:0] o_val;

  // Decimal split by constant divisors; every result fits in 0..9.
  always_comb begin
    h_val = value / 8'd100;
    t_val = (value / 8'd10) % 8'd10;
    o_val = value % 8'd10;
    hund  = ASCII_0 + h_val;
    tens  = ASCII_0 + t_val;
    ones  = ASCII_0 + o_val;
  end

endmodule

// File: rtl/fix_checksum_tx.sv
// Passes a FIX byte stream through and appends the "10=NNN<SOH>" checksum trailer.
// Latency: body bytes 0 cycles (combinational); trailer starts the cycle after last_i is accepted.
// Backpressure: ready_i passes straight to ready_o in PASS; trailer stalls in place while ready_i=0.
module fix_checksum_tx
  import fix_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  input  logic       last_i,
  output logic       ready_o,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       last_o,
  input  logic       ready_i,
  output logic [7:0] chk_o,
  output logic       chk_valid_o,
  output logic       fmt_err_o
);

  state_t     state;
  logic [7:0] sum;
  logic [2:0] idx;
  logic [7:0] chk;
  logic       fmt_err;
  logic [7:0] dig_hund;
  logic [7:0] dig_tens;
  logic [7:0] dig_ones;
  logic [7:0] trail_byte;
  logic       in_hs;
  logic       out_hs;

  chk_to_ascii3 u_digits (
    .value (chk),
    .hund  (dig_hund),
    .tens  (dig_tens),
    .ones  (dig_ones)
  );

  // Body byte accepted (PASS only) and trailer byte taken downstream (TRAIL only).
  assign in_hs  = !rst && (state == PASS) && valid_i && ready_i;
  assign out_hs = !rst && (state == TRAIL) && ready_i;

  // Pick the trailer byte for the current index.
  always_comb begin
    trail_byte = SOH;
    case (idx)
      3'd0:    trail_byte = ASCII_1;
      3'd1:    trail_byte = ASCII_0;
      3'd2:    trail_byte = ASCII_EQ;
      3'd3:    trail_byte = dig_hund;
      3'd4:    trail_byte = dig_tens;
      3'd5:    trail_byte = dig_ones;
      default: trail_byte = SOH;
    endcase
  end

  // Output mux: pass-through in PASS, generated trailer in TRAIL, quiet during reset.
  always_comb begin
    data_o  = data_i;
    valid_o = 1'b0;
    ready_o = 1'b0;
    last_o  = 1'b0;
    if (!rst) begin
      if (state == PASS) begin
        valid_o = valid_i;
        ready_o = ready_i;
      end else begin
        data_o  = trail_byte;
        valid_o = 1'b1;
        last_o  = (idx == LAST_IDX);
      end
    end
  end

  assign chk_o       = chk;
  assign fmt_err_o   = fmt_err;
  assign chk_valid_o = out_hs && (idx == LAST_IDX);

  // Accumulate body bytes, latch checksum on last_i, walk the trailer index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PASS;
      sum     <= 8'h00;
      idx     <= 3'd0;
      chk     <= 8'h00;
      fmt_err <= 1'b0;
    end else begin
      fmt_err <= 1'b0;
      if (in_hs) begin
        if (last_i) begin
          chk     <= sum + data_i;
          sum     <= 8'h00;
          idx     <= 3'd0;
          state   <= TRAIL;
          fmt_err <= (data_i != SOH);
        end else begin
          sum <= sum + data_i;
        end
      end
      if (out_hs) begin
        if (idx == LAST_IDX) begin
          idx   <= 3'd0;
          state <= PASS;
        end else begin
          idx <= idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: doc/fix_checksum_tx.md
Name: fix_checksum_tx

Overview:
- Transmit-side FIX trailer generator in the message egress path.
- Passes an outgoing FIX byte stream through unchanged and accumulates the byte sum modulo 256.
- After the last body byte it appends the trailer "10=NNN<SOH>", where NNN is the 3-digit zero-padded decimal checksum.
- It is the counterpart of the receive-side checksum checker: a checker on the far end must compute the same value from these bytes.

Parameters:
- SOH, 8'h01, field delimiter byte; appended at end of trailer and expected on the last input byte.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- data_i  in  8  upstream message byte
- valid_i  in  1  data_i valid
- last_i  in  1  data_i is the final body byte (the SOH ending the last field before tag 10)
- ready_o  out  1  block accepts data_i this cycle
- data_o  out  8  downstream byte
- valid_o  out  1  data_o valid
- last_o  out  1  data_o is the final trailer SOH
- ready_i  in  1  downstream accepts data_o this cycle
- chk_o  out  8  checksum of most recently completed message
- chk_valid_o  out  1  one-cycle pulse when trailer SOH is accepted downstream
- fmt_err_o  out  1  one-cycle pulse when a last_i byte is not SOH

Behaviour:
- Reset: rst is sampled on posedge clk. While rst=1 and on the following cycle:
  - FSM is in PASS, accumulator sum=0, trailer index idx=0.
  - chk_o=0; chk_valid_o, fmt_err_o, last_o and valid_o are 0; ready_o=0 while rst=1.
- Handshakes: in = valid_i&ready_o; out = valid_o&ready_i. Data is held stable while valid_o=1 and ready_i=0.
- FSM states PASS and TRAIL:
  - PASS is zero latency and combinational: data_o=data_i, valid_o=valid_i, ready_o=ready_i, last_o=0.
    - On in with last_i=0: sum <= sum+data_i, wrapping at 8 bits.
    - On in with last_i=1: chk_o <= sum+data_i (8-bit); sum <= 0; idx <= 0; go to TRAIL. If data_i!=SOH, also pulse fmt_err_o next cycle; the trailer is still appended.
  - TRAIL: ready_o=0 and valid_o=1. data_o by idx:
    - 0: 8'h31 ('1')
    - 1: 8'h30 ('0')
    - 2: 8'h3D ('=')
    - 3: hundreds digit of chk_o
    - 4: tens digit of chk_o
    - 5: ones digit of chk_o
    - 6: SOH, with last_o=1
    - Each digit is 8'h30 plus a value in 0..9.
    - On out: idx <= idx+1. At idx=6, chk_valid_o pulses the same cycle, the FSM returns to PASS and idx <= 0.
- Latency:
  - Body bytes: 0 cycles.
  - First trailer byte is presented the cycle after the last_i handshake.
  - With ready_i=1 the trailer occupies exactly 7 cycles, and a new message is accepted the cycle after the trailer SOH.
- Arithmetic: the sum covers every accepted byte from the first byte after the previous last_i up to and including the last_i byte. All arithmetic wraps mod 256 (the range of NNN is 000..255).
- Boundary conditions:
  - valid_i dropping mid-message: the sum is held.
  - A single-byte message (last_i on the first byte) is legal.
  - ready_i low at any trailer index: the FSM stalls with no skip or repeat.
  - rst asserted mid-body or mid-trailer aborts the message; no partial trailer continues after reset.
  - chk_o holds its value until the next last_i handshake.

Decomposition:
- Package fix_pkg holds:
  - SOH and the ASCII constants for '0', '1' and '='.
  - CHK_TAG_LEN=7.
  - The enum typedef for the PASS/TRAIL states.
- One sub-module, chk_to_ascii3: combinational 8-bit to three ASCII digits conversion (hundreds, tens, ones), instantiated on chk_o.

Test Plan:
- Bytes 0x41, 0x01(last), ready_i=1 -> out: 0x41 0x01 0x31 0x30 0x3D 0x30 0x36 0x36 0x01; last_o on the final byte; chk_o=0x42; chk_valid_o pulses once.
- Bytes 0xFF, 0xFF, 0x01(last) -> chk_o=0xFF; digits 0x32 0x35 0x35. Bytes 0xFF, 0x01(last) -> chk_o=0x00; digits 0x30 0x30 0x30 (wrap and zero padding).
- Backpressure:
  - ready_i=0 for 2 cycles while idx=3 -> data_o holds the hundreds digit and valid_o stays 1; trailer completes intact.
  - ready_o=0 throughout TRAIL.
- Back-to-back messages "A<SOH>" then "B<SOH>" -> second trailer "10=067<SOH>" (0x42+0x01); the accumulator starts fresh.
- Last byte 0x7C with last_i=1 -> fmt_err_o pulses once; trailer still emitted with chk_o equal to the byte sum.
- rst asserted during trailer idx=4 -> next cycle valid_o=0 and chk_valid_o=0. A new message "A<SOH>" then yields "10=066<SOH>".
